// File: rtl/shared_mult_scheduler_if.sv
// rtl/shared_mult_scheduler_if.sv - request/operand/result bundle between two cores and the shared multiplier
// Ports (signals):
//   Req0/Req1     level requests, held until the matching Done pulse
//   A0,B0/A1,B1   32-bit operands, valid while the matching Req is high
//   Done0/Done1   one-cycle pulse, Result valid for that core
//   Result        low 32 bits of the last product
//   Busy          multiplier is occupied
//   GrantId       index of the core currently owning the multiplier
interface shared_mult_scheduler_if;
    logic        Req0;
    logic [31:0] A0;
    logic [31:0] B0;
    logic        Req1;
    logic [31:0] A1;
    logic [31:0] B1;
    logic        Done0;
    logic        Done1;
    logic [31:0] Result;
    logic        Busy;
    logic        GrantId;

    modport master (
        output Req0, A0, B0, Req1, A1, B1,
        input  Done0, Done1, Result, Busy, GrantId
    );

    modport slave (
        input  Req0, A0, B0, Req1, A1, B1,
        output Done0, Done1, Result, Busy, GrantId
    );
endinterface

// File: rtl/shared_mult_scheduler.sv
// rtl/shared_mult_scheduler.sv - two-core arbiter in front of one 32-cycle shift-and-add multiplier
// Ports:
//   Clk    rising-edge clock
//   Reset  asynchronous active-high reset
//   bus    slave side of shared_mult_scheduler_if (requests/operands in, Done/Result/Busy/GrantId out)
module shared_mult_scheduler (
    input  logic                    Clk,
    input  logic                    Reset,
    shared_mult_scheduler_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic        grant_q, grant_d;
    logic        last_grant_q, last_grant_d;
    logic [31:0] acc_q, acc_d;
    logic [31:0] mcand_q, mcand_d;
    logic [31:0] mplr_q, mplr_d;
    logic [4:0]  count_q, count_d;
    logic [31:0] result_q, result_d;
    logic        done0_q, done0_d;
    logic        done1_q, done1_d;
    logic        pick;

    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        acc_d        = acc_q;
        mcand_d      = mcand_q;
        mplr_d       = mplr_q;
        count_d      = count_q;
        result_d     = result_q;
        done0_d      = 1'b0;
        done1_d      = 1'b0;
        pick         = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus.Req0 || bus.Req1) begin
                    // A tie goes to whoever did not win last time; a lone
                    // requester wins outright.
                    pick         = (bus.Req0 && bus.Req1) ? ~last_grant_q : bus.Req1;
                    grant_d      = pick;
                    last_grant_d = pick;
                    mcand_d      = pick ? bus.A1 : bus.A0;
                    mplr_d       = pick ? bus.B1 : bus.B0;
                    acc_d        = 32'd0;
                    count_d      = 5'd0;
                    state_d      = CALC;
                end
            end
            CALC: begin
                if (mplr_q[0]) begin
                    acc_d = acc_q + mcand_q;
                end
                mcand_d = mcand_q << 1;
                mplr_d  = mplr_q >> 1;
                count_d = count_q + 5'd1;
                if (count_q == 5'd31) begin
                    // Capture the final sum now so Result and the Done pulse
                    // are both visible during the single DONE cycle.
                    state_d  = DONE;
                    result_d = acc_d;
                    done0_d  = ~grant_q;
                    done1_d  = grant_q;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q      <= IDLE;
            grant_q      <= 1'b0;
            last_grant_q <= 1'b1;
            acc_q        <= 32'd0;
            mcand_q      <= 32'd0;
            mplr_q       <= 32'd0;
            count_q      <= 5'd0;
            result_q     <= 32'd0;
            done0_q      <= 1'b0;
            done1_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
            acc_q        <= acc_d;
            mcand_q      <= mcand_d;
            mplr_q       <= mplr_d;
            count_q      <= count_d;
            result_q     <= result_d;
            done0_q      <= done0_d;
            done1_q      <= done1_d;
        end
    end

    assign bus.Done0   = done0_q;
    assign bus.Done1   = done1_q;
    assign bus.Result  = result_q;
    assign bus.Busy    = (state_q != IDLE);
    assign bus.GrantId = grant_q;

endmodule

// File: tb/tb_shared_mult_scheduler.sv
// tb/tb_shared_mult_scheduler.sv - directed bench with a timeline model of the shared multiplier
module tb_shared_mult_scheduler;

    logic Clk = 1'b0;
    logic Reset = 1'b1;
    always #5 Clk = ~Clk;

    shared_mult_scheduler_if bus ();

    shared_mult_scheduler dut (
        .Clk   (Clk),
        .Reset (Reset),
        .bus   (bus)
    );

    int cyc = 0;
    always @(posedge Clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %h, required %h", name, cyc, act, exp);
        end
    endtask

    // Timeline model: an operation granted in cycle t finishes with its
    // product and Done pulse in cycle t+33, Busy covers t+1..t+33.
    bit          m_active;
    int          m_start;
    logic        m_owner;
    logic        m_last;
    logic        m_grant;
    logic [31:0] m_prod;
    logic [31:0] m_result;
    logic        e_d0, e_d1;
    logic [31:0] e_res;

    always @(negedge Clk) begin
        if (Reset) begin
            m_active = 1'b0;
            m_result = 32'd0;
            m_grant  = 1'b0;
            m_last   = 1'b1;
            check("reset_flags", {28'd0, bus.Busy, bus.Done0, bus.Done1, bus.GrantId}, 32'd0);
            check("reset_result", bus.Result, 32'd0);
        end else begin
            e_d0  = 1'b0;
            e_d1  = 1'b0;
            e_res = m_result;
            if (m_active && (cyc - m_start == 33)) begin
                e_res = m_prod;
                e_d0  = ~m_owner;
                e_d1  = m_owner;
            end
            check("model_flags", {28'd0, bus.Busy, bus.Done0, bus.Done1, bus.GrantId},
                  {28'd0, m_active, e_d0, e_d1, m_grant});
            check("model_result", bus.Result, e_res);

            if (m_active && (cyc - m_start == 33)) begin
                m_result = m_prod;
                m_active = 1'b0;
            end else if (!m_active && (bus.Req0 || bus.Req1)) begin
                m_owner  = (bus.Req0 && bus.Req1) ? ~m_last : bus.Req1;
                m_prod   = m_owner ? (bus.A1 * bus.B1) : (bus.A0 * bus.B0);
                m_active = 1'b1;
                m_start  = cyc;
                m_last   = m_owner;
                m_grant  = m_owner;
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) @(posedge Clk);
        #1;
    endtask

    task automatic do_reset();
        @(posedge Clk);
        #2;
        Reset    = 1'b1;
        bus.Req0 = 1'b0;
        bus.Req1 = 1'b0;
        @(posedge Clk);
        #1;
        Reset = 1'b0;
    endtask

    // Waits (bounded) for the chosen Done pulse, checks latency and result,
    // then returns 1ns into the cycle after Done.
    task automatic wait_done(input bit which, input int t0, input int exp_lat,
                             input logic [31:0] exp_res, input string name);
        int n;
        bit seen;
        n    = 0;
        seen = 1'b0;
        while (!seen && n < 80) begin
            @(negedge Clk);
            n++;
            if (which ? bus.Done1 : bus.Done0) seen = 1'b1;
        end
        check({name, "_seen"}, {31'd0, seen}, 32'd1);
        if (seen) begin
            check({name, "_latency"}, cyc - t0, exp_lat);
            check({name, "_result"}, bus.Result, exp_res);
        end
        @(posedge Clk);
        #1;
    endtask

    int t0;
    bit d1_seen;

    initial begin
        bus.Req0 = 1'b0; bus.A0 = 32'd0; bus.B0 = 32'd0;
        bus.Req1 = 1'b0; bus.A1 = 32'd0; bus.B1 = 32'd0;
        idle(3);
        Reset = 1'b0;
        check("post_reset_busy", {31'd0, bus.Busy}, 32'd0);
        check("post_reset_result", bus.Result, 32'd0);
        check("post_reset_grant", {31'd0, bus.GrantId}, 32'd0);
        idle(2);

        // Single core-0 request 7*6.
        bus.A0 = 32'd7; bus.B0 = 32'd6; bus.Req0 = 1'b1;
        t0 = cyc;
        wait_done(1'b0, t0, 33, 32'd42, "t1");
        bus.Req0 = 1'b0;
        idle(3);

        // Tie after reset: core 0 first, core 1 right after.
        do_reset();
        bus.A0 = 32'd3; bus.B0 = 32'd5;
        bus.A1 = 32'hFFFF_FFFE; bus.B1 = 32'd9;
        bus.Req0 = 1'b1; bus.Req1 = 1'b1;
        t0 = cyc;
        wait_done(1'b0, t0, 33, 32'd15, "t2_core0");
        bus.Req0 = 1'b0;
        idle(1);
        check("t2_grant_c35", {31'd0, bus.GrantId}, 32'd1);
        wait_done(1'b1, t0, 67, 32'hFFFF_FFEE, "t2_core1");
        bus.Req1 = 1'b0;
        idle(3);

        // Overflowing products.
        bus.A0 = 32'h0001_0000; bus.B0 = 32'h0001_0000; bus.Req0 = 1'b1;
        t0 = cyc;
        wait_done(1'b0, t0, 33, 32'h0000_0000, "t3_pow");
        bus.Req0 = 1'b0;
        idle(2);
        bus.A1 = 32'hFFFF_FFFF; bus.B1 = 32'hFFFF_FFFF; bus.Req1 = 1'b1;
        t0 = cyc;
        wait_done(1'b1, t0, 33, 32'h0000_0001, "t3_ones");
        bus.Req1 = 1'b0;
        idle(2);

        // Reset in CALC cycle 10 of a core-1 operation.
        bus.A1 = 32'd5; bus.B1 = 32'd7; bus.Req1 = 1'b1;
        t0 = cyc;
        repeat (10) @(posedge Clk);
        #2;
        Reset = 1'b1;
        #1;
        check("t4_busy_in_reset", {31'd0, bus.Busy}, 32'd0);
        check("t4_result_in_reset", bus.Result, 32'd0);
        bus.Req1 = 1'b0;
        @(posedge Clk);
        #1;
        Reset = 1'b0;
        d1_seen = 1'b0;
        repeat (40) begin
            @(negedge Clk);
            if (bus.Done1) d1_seen = 1'b1;
        end
        check("t4_no_done1", {31'd0, d1_seen}, 32'd0);
        @(posedge Clk);
        #1;
        bus.A0 = 32'd4; bus.B0 = 32'd4; bus.Req0 = 1'b1;
        t0 = cyc;
        wait_done(1'b0, t0, 33, 32'd16, "t4_after");
        bus.Req0 = 1'b0;
        idle(2);

        // Core 1 back-to-back, operands disturbed during CALC.
        do_reset();
        bus.A1 = 32'd3; bus.B1 = 32'd11; bus.Req1 = 1'b1;
        t0 = cyc;
        idle(5);
        bus.A1 = 32'd100; bus.B1 = 32'd77;
        wait_done(1'b1, t0, 33, 32'd33, "t5_first");
        bus.A1 = 32'd1000; bus.B1 = 32'd1000;
        wait_done(1'b1, t0, 67, 32'h000F_4240, "t5_second");
        bus.Req1 = 1'b0;
        idle(4);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/shared_mult_scheduler.md
SHARED_MULT_SCHEDULER -- requirements
Module: shared_mult_scheduler

Interface
REQ-001 The block SHALL have one clock and one reset; reset is asynchronous and active-high.
REQ-002 Port: Clk  input  1  rising-edge clock for all state.
REQ-003 Port: Reset  input  1  asynchronous active-high reset.
REQ-004 Port: Req0  input  1  core 0 multiply request, level, held until Done0.
REQ-005 Port: A0, B0  input  32 each  core 0 operands, valid while Req0 high.
REQ-006 Port: Req1  input  1  core 1 multiply request, level, held until Done1.
REQ-007 Port: A1, B1  input  32 each  core 1 operands, valid while Req1 high.
REQ-008 Port: Done0  output  1  one-cycle pulse: core 0 result valid on Result.
REQ-009 Port: Done1  output  1  one-cycle pulse: core 1 result valid on Result.
REQ-010 Port: Result  output  32  low 32 bits of the product, qualified by Done0/Done1.
REQ-011 Port: Busy  output  1  high while state is CALC or DONE.
REQ-012 Port: GrantId  output  1  index of the requester currently owning the unit.

Function
REQ-013 The FSM SHALL have states IDLE, CALC, DONE.
REQ-014 IDLE: with no request pending, stay in IDLE with Busy=0, Done0=Done1=0.
REQ-015 IDLE, exactly one Req high: grant it, latch its A (multiplicand) and B (multiplier), clear the accumulator, clear the 5-bit count, go to CALC.
REQ-016 IDLE, both Req high: grant the requester not equal to LastGrant; LastGrant <= granted index.
REQ-017 A lone requester SHALL be granted regardless of LastGrant.
REQ-018 CALC: every cycle, acc <= acc + mcand if mplr[0]=1; mcand <= mcand << 1; mplr <= mplr >> 1; count <= count + 1; all 32-bit arithmetic, carries out of bit 31 discarded.
REQ-019 CALC SHALL last exactly 32 cycles; when count = 31, go to DONE. There is no early termination.
REQ-020 DONE: Result <= acc and the Done bit selected by GrantId = 1 for exactly one cycle; next state IDLE unconditionally.
REQ-021 The result SHALL equal (A*B) mod 2^32, which is correct for both signed and unsigned operands.
REQ-022 Latency: with the request cycle in IDLE as cycle 0, Done is high in cycle 33; minimum spacing between two grants is 34 cycles.
REQ-023 The requester SHALL drop Req in the cycle after Done; a Req still high in IDLE is treated as a new request.
REQ-024 Operand or Req changes after the grant SHALL be ignored; a Req dropped during CALC does not abort the operation, and Done is still pulsed.
REQ-025 Result SHALL hold its last value until the next DONE.
REQ-026 GrantId SHALL hold its value from grant through DONE and remain unchanged in IDLE.

Reset
REQ-027 Reset SHALL force: state = IDLE, Done0 = Done1 = 0, Busy = 0, Result = 0, GrantId = 0, LastGrant = 1 (core 0 wins the first tie), accumulator, mcand, mplr and count = 0.
REQ-028 Reset asserted mid-CALC or in DONE SHALL abort the operation with no Done pulse; the first request after deassertion is served normally.

Verification
REQ-029 Req0=1, A0=7, B0=6 from cycle 0 -> Busy=1 in cycles 1-33, Done0=1 and Result=42 in cycle 33 only, Done1=0 throughout.
REQ-030 After reset, Req0 (3×5) and Req1 (0xFFFFFFFE×9) both high in cycle 0 -> Done0 in cycle 33 with Result=15; Done1 in cycle 67 with Result=0xFFFFFFEE; GrantId=1 during cycles 35-67.
REQ-031 Overflow -> 0x00010000×0x00010000 gives Result=0x00000000; 0xFFFFFFFF×0xFFFFFFFF gives Result=0x00000001.
REQ-032 Reset pulsed in CALC cycle 10 of a core-1 operation -> Busy=0 and Result=0 immediately, no Done1 pulse; then Req0 (4×4) gives Done0 with Result=16 33 cycles after its request cycle.
REQ-033 Core 1 alone issues two back-to-back requests (LastGrant=1) -> both are granted; Done1 appears in cycles 33 and 67; operand changes on A1 during CALC do not alter Result.
